// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Valid/ready character stream leaving the UART receive FIFO.
//
// Parameters
//   DATA_BITS  character width
//
// Signals
//   m_data   head-of-FIFO character (don't-care while m_valid is 0)
//   m_valid  m_data holds a stored character
//   m_ready  consumer accepts m_data when m_valid && m_ready
//
// Modports
//   master  the FIFO side (drives m_data / m_valid)
//   slave   the consumer side (drives m_ready)
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer placed directly after the UART receiver. Each completed
// character (signalled by a rising edge of rx_data_flag) is written into a
// circular register FIFO and presented downstream on a valid/ready stream with
// first-word fall-through. Characters arriving while the FIFO is full and not
// being drained are discarded and reported through a sticky overflow flag.
//
// Parameters
//   DATA_BITS  character width (matches the receiver)
//   DEPTH      FIFO entries, power of two, >= 2
//
// Ports
//   clk             system clock (same clock as the receiver)
//   reset_n         asynchronous active-low reset
//   rx_data         character from the receiver, stable while rx_data_flag high
//   rx_data_flag    character-complete level, high for one bit period
//   m_if            valid/ready output stream (master modport)
//   count           number of entries held
//   full / empty    decoded from count
//   overflow        sticky: a character was dropped
//   overflow_clear  clears overflow (a same-cycle drop wins)
//   drop_count      saturating dropped-character counter (optional)
//
// Optional feature
//   UART_RX_FIFO_DROP_CNT_EN  when defined, adds the drop_count[7:0] port and
//                             its saturating counter.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_BITS-1:0]         rx_data,
  input  logic                         rx_data_flag,
  uart_rx_fifo_if.master               m_if,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  input  logic                         overflow_clear
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

`ifdef UART_RX_FIFO_DROP_CNT_EN
  // Saturating increment for the 8-bit drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  logic                 flag_q;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 drop;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  // ---- Stage: flag edge detection and transfer decisions --------------------
  // flag_q resets high so a flag already asserted when reset releases
  // (mid-character) is not mistaken for a new character.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b1;
    end else begin
      flag_q <= rx_data_flag;
    end
  end

  assign push   = rx_data_flag && !flag_q;
  assign pop    = m_if.m_valid && m_if.m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // ---- Stage: storage and occupancy -----------------------------------------
  // Storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (accept && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !accept) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // ---- Stage: loss reporting ------------------------------------------------
  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  // Clear restarts counting; a drop in the clearing cycle counts as the first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (overflow_clear) begin
      drop_count <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      drop_count <= sat_inc8(drop_count);
    end
  end
`endif

  // ---- Stage: output decode (first-word fall-through) -----------------------
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign m_if.m_valid = !empty;
  assign m_if.m_data  = mem[rd_ptr];

endmodule
